// File: rtl/timebase_ctrl_if.sv
`default_nettype none
// ============================================================================
// timebase_ctrl_if : control/config/strobe bundle for timebase_ctrl
// TIMEBASE_ONESHOT_EN adds the oneshot request line.   Rev 1.0
// ============================================================================
interface timebase_ctrl_if #(
  parameter int unsigned TICK_W = 24
);
  logic              start;
  logic              stop;
`ifdef TIMEBASE_ONESHOT_EN
  logic              oneshot;
`endif
  logic              cfg_valid;
  logic [TICK_W-1:0] cfg_period;
  logic              cfg_ready;
  logic              pix_en;
  logic              tick;
  logic              tick_sq;
  logic              running;
  logic [TICK_W-1:0] cur_period;

`ifdef TIMEBASE_ONESHOT_EN
  modport master (
    output start, stop, oneshot, cfg_valid, cfg_period,
    input  cfg_ready, pix_en, tick, tick_sq, running, cur_period
  );
  modport slave (
    input  start, stop, oneshot, cfg_valid, cfg_period,
    output cfg_ready, pix_en, tick, tick_sq, running, cur_period
  );
`else
  modport master (
    output start, stop, cfg_valid, cfg_period,
    input  cfg_ready, pix_en, tick, tick_sq, running, cur_period
  );
  modport slave (
    input  start, stop, cfg_valid, cfg_period,
    output cfg_ready, pix_en, tick, tick_sq, running, cur_period
  );
`endif
endinterface
`default_nettype wire

// File: rtl/timebase_ctrl.sv
`default_nettype none
// ============================================================================
// timebase_ctrl : free-running pix_en prescaler plus run/stop tick generator
// with a valid/ready period port. Macro TIMEBASE_ONESHOT_EN enables one-tick runs.
// Rev 1.0
// ============================================================================
module timebase_ctrl #(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned TICK_W   = 24,
  parameter int unsigned TICK_DEF = 2500000
) (
  input  logic           clk,
  input  logic           rst_n,
  timebase_ctrl_if.slave bus
);

  localparam int unsigned         c_PDIV_W    = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [c_PDIV_W-1:0] c_PDIV_LAST = c_PDIV_W'(PIX_DIV - 1);
  localparam logic [c_PDIV_W-1:0] c_PDIV_PRE  = c_PDIV_W'(PIX_DIV - 2);
  localparam logic [c_PDIV_W-1:0] c_PDIV_ONE  = c_PDIV_W'(1);
  localparam logic [TICK_W-1:0]   c_TICK_DEF  = TICK_W'(TICK_DEF);
  localparam logic [TICK_W-1:0]   c_ONE       = TICK_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [c_PDIV_W-1:0] r_pdiv;
  logic [c_PDIV_W-1:0] w_pdiv_n;
  logic                r_pix_en;
  logic                w_pix_n;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [TICK_W-1:0]   w_cnt_n;
  logic [TICK_W-1:0]   r_cur_period;
  logic [TICK_W-1:0]   w_period_n;
  logic [TICK_W-1:0]   r_pend_period;
  logic [TICK_W-1:0]   w_pend_period_n;
  logic                r_pending;
  logic                w_pending_n;
  logic                r_cfg_ready;
  logic                r_tick;
  logic                w_tick_n;
  logic                r_tick_sq;
  logic                w_tick_sq_n;
  logic                w_accept;
  logic                w_apply;
  logic                w_oneshot_done;

`ifdef TIMEBASE_ONESHOT_EN
  logic r_oneshot;

  // Tracks the request line while idle so the value sampled with start is held for the run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_oneshot <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_oneshot <= bus.oneshot;
    end
  end

  assign w_oneshot_done = r_oneshot & r_tick;
`else
  assign w_oneshot_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: if (bus.start && !bus.stop) w_state_n = ST_RUN;
      ST_RUN:  if (bus.stop || w_oneshot_done) w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered, so each one is loaded from the value it must show next cycle.
  always_comb begin
    w_pdiv_n        = (r_pdiv == c_PDIV_LAST) ? '0 : r_pdiv + c_PDIV_ONE;
    w_pix_n         = (r_pdiv == c_PDIV_PRE);
    w_accept        = bus.cfg_valid && r_cfg_ready;
    w_apply         = r_pending && ((r_state == ST_IDLE) || r_tick);
    w_pend_period_n = r_pend_period;
    if (w_accept) begin
      w_pend_period_n = (bus.cfg_period == '0) ? c_ONE : bus.cfg_period;
    end
    w_pending_n = r_pending;
    if (w_accept) begin
      w_pending_n = 1'b1;
    end else if (w_apply) begin
      w_pending_n = 1'b0;
    end
    w_period_n = w_apply ? r_pend_period : r_cur_period;

    w_cnt_n = '0;
    if ((r_state == ST_RUN) && (w_state_n == ST_RUN)) begin
      if (r_pix_en) begin
        w_cnt_n = r_tick ? '0 : r_tick_cnt + c_ONE;
      end else begin
        w_cnt_n = r_tick_cnt;
      end
    end

    w_tick_n = (w_state_n == ST_RUN) && w_pix_n && (w_cnt_n == w_period_n - c_ONE);

    w_tick_sq_n = r_tick_sq;
    if (w_state_n == ST_IDLE) begin
      w_tick_sq_n = 1'b0;
    end else if (w_tick_n) begin
      w_tick_sq_n = ~r_tick_sq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pdiv        <= '0;
      r_pix_en      <= 1'b0;
      r_tick_cnt    <= '0;
      r_cur_period  <= c_TICK_DEF;
      r_pend_period <= c_TICK_DEF;
      r_pending     <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_tick        <= 1'b0;
      r_tick_sq     <= 1'b0;
    end else begin
      r_pdiv        <= w_pdiv_n;
      r_pix_en      <= w_pix_n;
      r_tick_cnt    <= w_cnt_n;
      r_cur_period  <= w_period_n;
      r_pend_period <= w_pend_period_n;
      r_pending     <= w_pending_n;
      r_cfg_ready   <= ~w_pending_n;
      r_tick        <= w_tick_n;
      r_tick_sq     <= w_tick_sq_n;
    end
  end

  assign bus.pix_en     = r_pix_en;
  assign bus.tick       = r_tick;
  assign bus.tick_sq    = r_tick_sq;
  assign bus.running    = (r_state == ST_RUN);
  assign bus.cfg_ready  = r_cfg_ready;
  assign bus.cur_period = r_cur_period;

endmodule
`default_nettype wire

// File: tb/tb_timebase_ctrl.sv
`default_nettype none
// tb_timebase_ctrl : directed checks of prescaler, run/stop, config handshake and reset.
module tb_timebase_ctrl;

  localparam int unsigned       TICK_W   = 24;
  localparam int unsigned       PIX_DIV  = 4;
  localparam logic [TICK_W-1:0] TICK_DEF = 24'd2500000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  timebase_ctrl_if #(.TICK_W(TICK_W)) bus ();

  timebase_ctrl #(
    .PIX_DIV (PIX_DIV),
    .TICK_W  (TICK_W),
    .TICK_DEF(2500000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;          // posedges since reset release; pix_en expected when cyc%4==3
  int   m_cnt = 0;
  int   m_period = 2500000;
  int   m_pend = 0;
  logic m_sq = 1'b0;
  logic m_run = 1'b0;
  logic m_pending = 1'b0;
  logic e_pix;
  logic e_tick;

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if (bus.pix_en !== 1'b0 || bus.tick !== 1'b0 || bus.tick_sq !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes: pix_en/tick/tick_sq=%b%b%b want 000", bus.pix_en, bus.tick, bus.tick_sq);
    end
    total++;
    if (bus.running !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctrl: running=%b cfg_ready=%b want 0 1", bus.running, bus.cfg_ready);
    end
    total++;
    if (bus.cur_period !== TICK_DEF) begin
      bad++;
      $display("FAIL reset_period: cur_period=%0d want %0d", bus.cur_period, TICK_DEF);
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_prescaler();
    for (int i = 0; i < 12; i++) begin
      step();
      e_pix = (cyc % 4 == 3);
      total++;
      if (bus.pix_en !== e_pix || bus.tick !== 1'b0 || bus.tick_sq !== 1'b0 || bus.running !== 1'b0) begin
        bad++;
        $display("FAIL prescaler cyc=%0d: pix_en/tick/tick_sq/running=%b%b%b%b want %b000",
                 cyc, bus.pix_en, bus.tick, bus.tick_sq, bus.running, e_pix);
      end
    end
    total++;
    if (bus.cur_period !== TICK_DEF) begin
      bad++;
      $display("FAIL prescaler_period: cur_period=%0d want %0d", bus.cur_period, TICK_DEF);
    end
  endtask

  task automatic test_cfg_idle();
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 24'd3;
    step();
    bus.cfg_valid  = 1'b0;
    bus.cfg_period = 24'd0;
    total++;
    if (bus.cfg_ready !== 1'b0 || bus.cur_period !== TICK_DEF) begin
      bad++;
      $display("FAIL cfg_idle_pending: cfg_ready=%b cur_period=%0d want 0 %0d", bus.cfg_ready, bus.cur_period, TICK_DEF);
    end
    step();
    total++;
    if (bus.cfg_ready !== 1'b1 || bus.cur_period !== 24'd3) begin
      bad++;
      $display("FAIL cfg_idle_apply: cfg_ready=%b cur_period=%0d want 1 3", bus.cfg_ready, bus.cur_period);
    end
    m_period = 3;
  endtask

  task automatic test_run_period3();
    int ticks;
    ticks     = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_run = 1'b1;
    m_cnt = 0;
    m_sq  = 1'b0;
    for (int i = 0; i < 36; i++) begin
      e_pix  = (cyc % 4 == 3);
      e_tick = 1'b0;
      if (e_pix) begin
        m_cnt++;
        if (m_cnt == m_period) begin
          e_tick = 1'b1;
          m_cnt  = 0;
          m_sq   = ~m_sq;
        end
      end
      if (bus.tick === 1'b1) ticks++;
      total++;
      if (bus.pix_en !== e_pix || bus.tick !== e_tick || bus.tick_sq !== m_sq || bus.running !== 1'b1) begin
        bad++;
        $display("FAIL run3 cyc=%0d: pix_en/tick/tick_sq/running=%b%b%b%b want %b%b%b1",
                 cyc, bus.pix_en, bus.tick, bus.tick_sq, bus.running, e_pix, e_tick, m_sq);
      end
      step();
    end
    total++;
    if (ticks != 3) begin
      bad++;
      $display("FAIL run3_count: ticks=%0d want 3", ticks);
    end
  endtask

  task automatic test_reconfig_run();
    bit found;
    int pixn;
    int ticks;
    int first_pix;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      e_pix  = (cyc % 4 == 3);
      e_tick = 1'b0;
      if (e_pix) begin
        m_cnt++;
        if (m_cnt == m_period) begin
          e_tick = 1'b1;
          m_cnt  = 0;
          m_sq   = ~m_sq;
        end
      end
      total++;
      if (bus.tick !== e_tick || bus.tick_sq !== m_sq) begin
        bad++;
        $display("FAIL reconfig_sync cyc=%0d: tick/tick_sq=%b%b want %b%b", cyc, bus.tick, bus.tick_sq, e_tick, m_sq);
      end
      if (e_tick) found = 1'b1;
      else step();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL reconfig_timeout: no tick within 40 cycles, want one");
    end
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 24'd5;
    step();
    bus.cfg_valid  = 1'b0;
    bus.cfg_period = 24'd0;
    m_pending = 1'b1;
    m_pend    = 5;
    pixn = 0;
    ticks = 0;
    first_pix = 0;
    for (int i = 0; i < 60; i++) begin
      e_pix  = (cyc % 4 == 3);
      e_tick = 1'b0;
      if (e_pix) begin
        pixn++;
        m_cnt++;
        if (m_cnt == m_period) begin
          e_tick = 1'b1;
          m_cnt  = 0;
          m_sq   = ~m_sq;
        end
      end
      if (bus.tick === 1'b1) begin
        ticks++;
        if (ticks == 1) first_pix = pixn;
      end
      total++;
      if (bus.pix_en !== e_pix || bus.tick !== e_tick || bus.tick_sq !== m_sq ||
          bus.cfg_ready !== ~m_pending || bus.cur_period !== TICK_W'(m_period)) begin
        bad++;
        $display("FAIL reconfig cyc=%0d: pix/tick/sq/ready=%b%b%b%b period=%0d want %b%b%b%b period=%0d",
                 cyc, bus.pix_en, bus.tick, bus.tick_sq, bus.cfg_ready, bus.cur_period,
                 e_pix, e_tick, m_sq, ~m_pending, m_period);
      end
      if (e_tick && m_pending) begin
        m_period  = m_pend;
        m_pending = 1'b0;
      end
      step();
    end
    total++;
    if (ticks != 3 || first_pix != 3) begin
      bad++;
      $display("FAIL reconfig_spacing: ticks=%0d first_at_pix=%0d want 3 and 3", ticks, first_pix);
    end
  endtask

  task automatic test_start_stop_same();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    m_run = 1'b0;
    m_cnt = 0;
    m_sq  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      e_pix = (cyc % 4 == 3);
      total++;
      if (bus.pix_en !== e_pix || bus.tick !== 1'b0 || bus.tick_sq !== 1'b0 || bus.running !== 1'b0) begin
        bad++;
        $display("FAIL start_stop cyc=%0d: pix/tick/sq/running=%b%b%b%b want %b000",
                 cyc, bus.pix_en, bus.tick, bus.tick_sq, bus.running, e_pix);
      end
      step();
    end
  endtask

  task automatic test_period_zero();
    int ticks;
    ticks = 0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 24'd0;
    step();
    bus.cfg_valid = 1'b0;
    step();
    total++;
    if (bus.cur_period !== 24'd1 || bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL period_zero_apply: cur_period=%0d cfg_ready=%b want 1 1", bus.cur_period, bus.cfg_ready);
    end
    m_period  = 1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_run = 1'b1;
    m_cnt = 0;
    m_sq  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      e_pix  = (cyc % 4 == 3);
      e_tick = e_pix;
      if (e_tick) m_sq = ~m_sq;
      if (bus.tick === 1'b1) ticks++;
      total++;
      if (bus.pix_en !== e_pix || bus.tick !== e_tick || bus.tick_sq !== m_sq) begin
        bad++;
        $display("FAIL period_one cyc=%0d: pix/tick/sq=%b%b%b want %b%b%b",
                 cyc, bus.pix_en, bus.tick, bus.tick_sq, e_pix, e_tick, m_sq);
      end
      step();
    end
    total++;
    if (ticks != 6) begin
      bad++;
      $display("FAIL period_one_count: ticks=%0d want 6", ticks);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (cyc % 4 == 3) found = 1'b1;
      else step();
    end
    total++;
    if (bus.tick !== 1'b1) begin
      bad++;
      $display("FAIL midrun_tick: tick=%b want 1", bus.tick);
    end
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 24'd9;
    step();
    bus.cfg_valid  = 1'b0;
    bus.cfg_period = 24'd0;
    total++;
    if (bus.cfg_ready !== 1'b0 || bus.running !== 1'b1) begin
      bad++;
      $display("FAIL midrun_pending: cfg_ready=%b running=%b want 0 1", bus.cfg_ready, bus.running);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (bus.pix_en !== 1'b0 || bus.tick !== 1'b0 || bus.tick_sq !== 1'b0 || bus.running !== 1'b0 ||
        bus.cfg_ready !== 1'b1 || bus.cur_period !== TICK_DEF) begin
      bad++;
      $display("FAIL midrun_reset: pix/tick/sq/run/ready=%b%b%b%b%b period=%0d want 00001 period=%0d",
               bus.pix_en, bus.tick, bus.tick_sq, bus.running, bus.cfg_ready, bus.cur_period, TICK_DEF);
    end
    rst_n = 1'b1;
    cyc   = 0;
    m_run = 1'b0;
    m_period  = 2500000;
    m_pending = 1'b0;
    m_sq  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      e_pix = (cyc % 4 == 3);
      total++;
      if (bus.pix_en !== e_pix || bus.cur_period !== TICK_DEF || bus.cfg_ready !== 1'b1 || bus.running !== 1'b0) begin
        bad++;
        $display("FAIL after_reset cyc=%0d: pix=%b period=%0d ready=%b running=%b want %b %0d 1 0",
                 cyc, bus.pix_en, bus.cur_period, bus.cfg_ready, bus.running, e_pix, TICK_DEF);
      end
    end
  endtask

`ifdef TIMEBASE_ONESHOT_EN
  task automatic test_oneshot();
    int ticks;
    bit after;
    ticks = 0;
    after = 1'b0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 24'd2;
    step();
    bus.cfg_valid = 1'b0;
    step();
    bus.start   = 1'b1;
    bus.oneshot = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.oneshot = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (after) begin
        total++;
        if (bus.running !== 1'b0 || bus.tick_sq !== 1'b0) begin
          bad++;
          $display("FAIL oneshot_drop: running=%b tick_sq=%b want 0 0", bus.running, bus.tick_sq);
        end
        after = 1'b0;
      end
      if (bus.tick === 1'b1) begin
        ticks++;
        after = 1'b1;
      end
      step();
    end
    total++;
    if (ticks != 1 || bus.running !== 1'b0 || bus.tick_sq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot: ticks=%0d running=%b tick_sq=%b want 1 0 0", ticks, bus.running, bus.tick_sq);
    end
  endtask
`endif

  initial begin
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_period = 24'd0;
`ifdef TIMEBASE_ONESHOT_EN
    bus.oneshot    = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_prescaler();
    test_cfg_idle();
    test_run_period3();
    test_reconfig_run();
    test_start_stop_same();
    test_period_zero();
    test_reset_mid_run();
`ifdef TIMEBASE_ONESHOT_EN
    test_oneshot();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
